// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the synchronous data memory between the core load/store
//            stage and the host port; one access per cycle, bounded host wait.
// Revision : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_CORE_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] c_OWN_NONE   = 2'd0;
  localparam logic [1:0] c_OWN_CORE   = 2'd1;
  localparam logic [1:0] c_OWN_HOST   = 2'd2;
  localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_rd_own;
  logic [1:0]  w_rd_own_nxt;
  logic [3:0]  r_starve_cnt;
  logic [3:0]  w_starve_nxt;
  logic        w_core_elig;
  logic        w_host_win;
  logic        w_core_win;
  logic        w_core_rd;
  logic        w_host_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_rd_own     <= c_OWN_NONE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_own     <= w_rd_own_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    // Every request term is qualified by reset so all outputs drop while it is held.
    w_core_elig = reset & core_req & (r_state == ST_IDLE);
    w_host_win  = reset & host_req & (~w_core_elig | (r_starve_cnt == c_STARVE_MAX));
    w_core_win  = w_core_elig & ~w_host_win;
    w_core_rd   = w_core_win & ~core_we;
    w_host_rd   = w_host_win & ~host_we;

    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE:      w_state_nxt = w_core_rd ? ST_CORE_WAIT : ST_IDLE;
      ST_CORE_WAIT: w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase

    w_rd_own_nxt = c_OWN_NONE;
    if (w_core_rd) begin
      w_rd_own_nxt = c_OWN_CORE;
    end else if (w_host_rd) begin
      w_rd_own_nxt = c_OWN_HOST;
    end

    w_starve_nxt = 4'd0;
    if (host_req && !w_host_win) begin
      w_starve_nxt = (r_starve_cnt >= c_STARVE_MAX) ? c_STARVE_MAX : r_starve_cnt + 4'd1;
    end

    mem_re    = w_core_rd | w_host_rd;
    mem_we    = (w_core_win & core_we) | (w_host_win & host_we);
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_core_win) begin
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (w_host_win) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end

    // A core store that wins completes this cycle; anything else eligible must hold.
    core_stall  = w_core_elig & ~(w_core_win & core_we);
    host_gnt    = w_host_win;
    core_rvalid = reset & (r_rd_own == c_OWN_CORE);
    host_rvalid = reset & (r_rd_own == c_OWN_HOST);
    core_rdata  = core_rvalid ? mem_rdata : '0;
    host_rdata  = host_rvalid ? mem_rdata : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Randomized scoreboard bench for dmem_arbiter with a behavioural
//            arbitration model and a synchronous memory macro.
// Revision : 1.0
// ============================================================================
module tb_dmem_arbiter;
  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 3;
  localparam int c_SPAN       = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              core_req = 1'b0;
  logic              core_we = 1'b0;
  logic [ADDR_W-1:0] core_addr = '0;
  logic [DATA_W-1:0] core_wdata = '0;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .core_rdata (core_rdata),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
    .host_rdata (host_rdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory macro; the read port outputs junk when not strobed so ungated data shows up.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
    else        mem_rdata <= $urandom;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one access per cycle, core preferred unless the host has waited long enough.
  logic [DATA_W-1:0] ref_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] core_q[$];
  logic [DATA_W-1:0] host_q[$];
  bit mdl_core_ret = 1'b0;
  bit mdl_host_ret = 1'b0;
  int mdl_wait     = 0;
  bit last_stall   = 1'b0;
  bit last_gnt     = 1'b0;

  always @(negedge clk) begin : p_model
    bit                core_can;
    bit                host_win;
    bit                core_win;
    logic [14:0]       exp_ctl;
    logic [DATA_W-1:0] exp_wd;
    exp_ctl  = '0;
    exp_wd   = '0;
    core_can = 1'b0;
    host_win = 1'b0;
    core_win = 1'b0;
    if (reset) begin
      core_can = core_req && !mdl_core_ret;
      host_win = host_req && (!core_can || mdl_wait >= STARVE_LIMIT);
      core_win = core_can && !host_win;
      exp_ctl[14] = core_can && !(core_win && core_we);
      exp_ctl[13] = mdl_core_ret;
      exp_ctl[12] = host_win;
      exp_ctl[11] = mdl_host_ret;
      exp_ctl[10] = (core_win && !core_we) || (host_win && !host_we);
      exp_ctl[9]  = (core_win && core_we) || (host_win && host_we);
      exp_ctl[8:0] = core_win ? core_addr : (host_win ? host_addr : '0);
      exp_wd       = core_win ? core_wdata : (host_win ? host_wdata : '0);
    end
    check("ctrl{stall,crv,gnt,hrv,re,we,addr}",
          {core_stall, core_rvalid, host_gnt, host_rvalid, mem_re, mem_we, mem_addr}, exp_ctl);
    check("mem_wdata", mem_wdata, exp_wd);
    last_stall = core_stall;
    last_gnt   = host_gnt;
    if (reset) begin
      if (core_win) begin
        if (core_we) ref_mem[core_addr] = core_wdata;
        else         core_q.push_back(ref_mem[core_addr]);
      end
      if (host_win) begin
        if (host_we) ref_mem[host_addr] = host_wdata;
        else         host_q.push_back(ref_mem[host_addr]);
      end
      mdl_core_ret = core_win && !core_we;
      mdl_host_ret = host_win && !host_we;
      if (host_req && !host_win) mdl_wait = (mdl_wait < STARVE_LIMIT) ? mdl_wait + 1 : mdl_wait;
      else                       mdl_wait = 0;
    end else begin
      mdl_core_ret = 1'b0;
      mdl_host_ret = 1'b0;
      mdl_wait     = 0;
      core_q.delete();
      host_q.delete();
    end
  end

  always @(negedge clk) begin : p_monitor
    logic [DATA_W-1:0] exp_d;
    if (core_rvalid) begin
      if (core_q.size() == 0) check("core_rvalid_orphan", core_rvalid, 1'b0);
      else begin
        exp_d = core_q.pop_front();
        check("core_rdata", core_rdata, exp_d);
      end
    end else begin
      check("core_rdata_idle", core_rdata, '0);
    end
    if (host_rvalid) begin
      if (host_q.size() == 0) check("host_rvalid_orphan", host_rvalid, 1'b0);
      else begin
        exp_d = host_q.pop_front();
        check("host_rdata", host_rdata, exp_d);
      end
    end else begin
      check("host_rdata_idle", host_rdata, '0);
    end
  end

  task automatic do_host(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(posedge clk); #1;
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (host_gnt) break;
    end
    check("host_gnt_seen", host_gnt, 1'b1);
    @(posedge clk); #1;
    host_req = 1'b0;
  endtask

  task automatic do_core(input bit we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!core_stall) break;
    end
    check("core_released", core_stall, 1'b0);
    @(posedge clk); #1;
    core_req = 1'b0;
  endtask

  // Protocol-following random driver: requests are held until accepted.
  task automatic drive_cycles(input int n, input int core_pct, input int store_pct,
                              input int host_pct, input int hwr_pct);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (!(core_req && last_stall)) begin
        core_req   = int'($urandom_range(99)) < core_pct;
        core_we    = int'($urandom_range(99)) < store_pct;
        core_addr  = ADDR_W'($urandom_range(c_SPAN - 1));
        core_wdata = $urandom;
      end
      if (!(host_req && !last_gnt)) begin
        host_req   = int'($urandom_range(99)) < host_pct;
        host_we    = int'($urandom_range(99)) < hwr_pct;
        host_addr  = ADDR_W'($urandom_range(c_SPAN - 1));
        host_wdata = $urandom;
      end
    end
  endtask

  initial begin : p_watchdog
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    for (int a = 0; a < c_SPAN; a++) do_host(1'b1, ADDR_W'(a), $urandom);

    do_host(1'b1, 9'h010, 32'hDEADBEEF);
    do_core(1'b0, 9'h010, '0);
    do_core(1'b1, 9'h020, 32'h12345678);
    do_host(1'b0, 9'h020, '0);

    drive_cycles(10, 100, 100, 100, 0);
    drive_cycles(8, 0, 0, 0, 0);
    drive_cycles(10, 100, 0, 100, 0);
    drive_cycles(8, 0, 0, 0, 0);
    drive_cycles(3000, 70, 40, 50, 30);
    drive_cycles(10, 0, 0, 0, 0);

    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 9'h010;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("reset_ctrl_zero",
          {core_stall, core_rvalid, host_gnt, host_rvalid, mem_re, mem_we, mem_addr}, '0);
    check("reset_data_zero", mem_wdata | core_rdata | host_rdata, '0);
    core_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    drive_cycles(12, 0, 0, 0, 0);

    check("queues_drained", core_q.size() + host_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
